dht11_responder: RTL and testbench

DHT11_RESPONDER -- requirements
Module: dht11_responder

---
 rtl/dht11_pkg.sv | 38 +++
 rtl/dht11_us_tick.sv | 38 +++
 rtl/dht11_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dht11_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg
// Shared definitions for the DHT11 sensor responder:
//   - dht11_state_e   : FSM state encoding
//   - DEF_*           : default clock and phase timing constants (us)
//   - FRAME_BITS      : number of bits in one sensor frame
//   - dht11_checksum  : modulo-256 sum of the four measurement bytes
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HOST_LOW   = 3'd1,
    ST_RESP_DELAY = 3'd2,
    ST_RESP_LOW   = 3'd3,
    ST_RESP_HIGH  = 3'd4,
    ST_BIT_LOW    = 3'd5,
    ST_BIT_HIGH   = 3'd6,
    ST_END_LOW    = 3'd7
  } dht11_state_e;

  localparam int unsigned DEF_CLK_FREQ      = 32'd50000000;
  localparam int unsigned DEF_START_MIN_US  = 32'd18000;
  localparam int unsigned DEF_RESP_DELAY_US = 32'd30;
  localparam int unsigned DEF_RESP_LOW_US   = 32'd80;
  localparam int unsigned DEF_RESP_HIGH_US  = 32'd80;
  localparam int unsigned DEF_BIT_LOW_US    = 32'd50;
  localparam int unsigned DEF_BIT0_HIGH_US  = 32'd26;
  localparam int unsigned DEF_BIT1_HIGH_US  = 32'd70;
  localparam int unsigned DEF_END_LOW_US    = 32'd50;

  localparam int unsigned FRAME_BITS = 32'd40;

  // 8-bit sum wraps naturally, giving the modulo-256 checksum.
  function automatic logic [7:0] dht11_checksum(input logic [7:0] hi, input logic [7:0] hd,
                                                input logic [7:0] ti, input logic [7:0] td);
    return hi + hd + ti + td;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick
// Free-running 1 us tick divider that can be restarted.
//   clock   : system clock
//   reset   : asynchronous active-low reset
//   restart : first cycle of a new phase; the divider counts this cycle as its cycle 0
//   tick    : high on the last cycle of every DIV-cycle period
// Because the restart cycle itself is counted, N ticks after a restart end exactly
// N*DIV cycles after the restart cycle began.
module dht11_us_tick #(
  parameter int unsigned DIV = 32'd50
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_eff;

  assign w_cnt_eff = restart ? {CW{1'b0}} : r_cnt;
  assign tick      = (w_cnt_eff == LAST);

  // Divider counter: wraps after each tick, restarts from the phase boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (tick) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= w_cnt_eff + CW'(1);
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder
// Emulates a DHT11 sensor on an open-drain single-wire bus.
//   clock, reset            : system clock, asynchronous active-low reset
//   transmission_line       : open-drain bus; only ever driven 0 or released (Z)
//   humidity_int/_dec,
//   temperature_int/_dec    : measurement bytes reported in the next frame
//   busy                    : high from an accepted start until the frame ends
//   frame_done              : one-cycle pulse after the 40th bit and end-low phase
//   start_rejected          : one-cycle pulse when a too-short host-low pulse ends
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
  parameter int unsigned START_MIN_US  = DEF_START_MIN_US,
  parameter int unsigned RESP_DELAY_US = DEF_RESP_DELAY_US,
  parameter int unsigned RESP_LOW_US   = DEF_RESP_LOW_US,
  parameter int unsigned RESP_HIGH_US  = DEF_RESP_HIGH_US,
  parameter int unsigned BIT_LOW_US    = DEF_BIT_LOW_US,
  parameter int unsigned BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
  parameter int unsigned BIT1_HIGH_US  = DEF_BIT1_HIGH_US,
  parameter int unsigned END_LOW_US    = DEF_END_LOW_US
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        transmission_line,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       start_rejected
);

  localparam int unsigned US_DIV = (CLK_FREQ >= 32'd1000000) ? (CLK_FREQ / 32'd1000000) : 32'd1;
  localparam logic [15:0] START_MIN = 16'(START_MIN_US);

  logic                    r_sync1;
  logic                    r_sync2;
  dht11_state_e            r_state;
  logic [15:0]             r_us;
  logic [5:0]              r_bit_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_drive_low;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    r_start_rejected;
  logic                    r_restart;

  logic                    w_tick;
  logic [15:0]             w_last;
  logic                    w_timed;
  logic                    w_phase_end;

  dht11_us_tick #(.DIV(US_DIV)) u_us_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (r_restart),
    .tick    (w_tick)
  );

  // Open drain: only ever pull low or release; reset clears r_drive_low asynchronously.
  assign transmission_line = r_drive_low ? 1'b0 : 1'bz;

  assign busy           = r_busy;
  assign frame_done     = r_frame_done;
  assign start_rejected = r_start_rejected;

  // Last us index of the current timed phase (phase ends on the tick where r_us hits it).
  always_comb begin
    w_last = 16'd0;
    case (r_state)
      ST_RESP_DELAY: w_last = 16'(RESP_DELAY_US - 32'd1);
      ST_RESP_LOW:   w_last = 16'(RESP_LOW_US - 32'd1);
      ST_RESP_HIGH:  w_last = 16'(RESP_HIGH_US - 32'd1);
      ST_BIT_LOW:    w_last = 16'(BIT_LOW_US - 32'd1);
      ST_BIT_HIGH:   w_last = r_shift[FRAME_BITS-1] ? 16'(BIT1_HIGH_US - 32'd1)
                                                    : 16'(BIT0_HIGH_US - 32'd1);
      ST_END_LOW:    w_last = 16'(END_LOW_US - 32'd1);
      default:       w_last = 16'd0;
    endcase
  end

  assign w_timed     = (r_state != ST_IDLE) && (r_state != ST_HOST_LOW);
  assign w_phase_end = w_timed && w_tick && (r_us == w_last);

  // Two-flop synchronizer; resets to the released (high) level so a start is
  // only seen two cycles after reset deassertion at the earliest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= transmission_line;
      r_sync2 <= r_sync1;
    end
  end

  // Responder FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_us             <= 16'd0;
      r_bit_cnt        <= 6'd0;
      r_shift          <= {FRAME_BITS{1'b0}};
      r_drive_low      <= 1'b0;
      r_busy           <= 1'b0;
      r_frame_done     <= 1'b0;
      r_start_rejected <= 1'b0;
      r_restart        <= 1'b0;
    end else begin
      r_frame_done     <= 1'b0;
      r_start_rejected <= 1'b0;
      r_restart        <= 1'b0;

      // Shared us timing of all frame phases; the line is ignored here.
      if (w_timed) begin
        if (w_phase_end) begin
          r_us      <= 16'd0;
          r_restart <= 1'b1;
        end else if (w_tick) begin
          r_us <= r_us + 16'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            r_state   <= ST_HOST_LOW;
            r_us      <= 16'd0;
            r_restart <= 1'b1;
          end
        end
        ST_HOST_LOW: begin
          if (r_sync2) begin
            r_us      <= 16'd0;
            r_restart <= 1'b1;
            if (r_us >= START_MIN) begin
              r_state   <= ST_RESP_DELAY;
              r_busy    <= 1'b1;
              r_bit_cnt <= 6'd0;
              r_shift   <= {humidity_int, humidity_dec, temperature_int, temperature_dec,
                            dht11_checksum(humidity_int, humidity_dec,
                                           temperature_int, temperature_dec)};
            end else begin
              r_state          <= ST_IDLE;
              r_start_rejected <= 1'b1;
            end
          end else if (w_tick && (r_us < START_MIN)) begin
            r_us <= r_us + 16'd1;
          end
        end
        ST_RESP_DELAY: begin
          if (w_phase_end) begin
            r_state     <= ST_RESP_LOW;
            r_drive_low <= 1'b1;
          end
        end
        ST_RESP_LOW: begin
          if (w_phase_end) begin
            r_state     <= ST_RESP_HIGH;
            r_drive_low <= 1'b0;
          end
        end
        ST_RESP_HIGH: begin
          if (w_phase_end) begin
            r_state     <= ST_BIT_LOW;
            r_drive_low <= 1'b1;
          end
        end
        ST_BIT_LOW: begin
          if (w_phase_end) begin
            r_state     <= ST_BIT_HIGH;
            r_drive_low <= 1'b0;
          end
        end
        ST_BIT_HIGH: begin
          if (w_phase_end) begin
            r_shift     <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_bit_cnt   <= r_bit_cnt + 6'd1;
            r_drive_low <= 1'b1;
            r_state     <= (r_bit_cnt == 6'(FRAME_BITS - 32'd1)) ? ST_END_LOW : ST_BIT_LOW;
          end
        end
        ST_END_LOW: begin
          if (w_phase_end) begin
            r_state      <= ST_IDLE;
            r_drive_low  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_drive_low <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
`timescale 1ns/1ps
// tb_dht11_responder
// Directed bench: acts as the host on the open-drain bus (pull-up plus host
// pull-down), decodes the responder's frames by measuring phase widths in
// clock cycles, and compares against hand-computed frames.
// Clock is 2 MHz (2 cycles per us); start threshold scaled to 180 us.
module tb_dht11_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_rst_n;
  logic       r_host_low;
  logic [7:0] hi, hd, ti, td;
  logic       busy, fd, rej;
  wire        line;

  pullup (line);
  assign line = r_host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .CLK_FREQ     (2000000),
    .START_MIN_US (180)
  ) dut (
    .clock             (clk),
    .reset             (r_rst_n),
    .transmission_line (line),
    .humidity_int      (hi),
    .humidity_dec      (hd),
    .temperature_int   (ti),
    .temperature_dec   (td),
    .busy              (busy),
    .frame_done        (fd),
    .start_rejected    (rej)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt = 0, rej_cnt = 0, busy_cnt = 0, dut_low_cnt = 0;
  bit g_abort = 1'b0;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (fd)  fd_cnt  <= fd_cnt + 1;
    if (rej) rej_cnt <= rej_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!r_host_low && line === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count cycles the line stays at lvl; bounded so a stuck line cannot hang the run.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    if (!g_abort) begin
      while (line === lvl && n < 4000) begin
        n++;
        @(negedge clk);
      end
      if (n >= 4000) begin
        g_abort = 1'b1;
        check_eq("phase_timeout", 64'(n), 64'd0);
      end
    end
  endtask

  task automatic host_start(input int us);
    r_host_low = 1'b1;
    repeat (us * 2) @(negedge clk);
    r_host_low = 1'b0;
    @(negedge clk);
  endtask

  // Decode one frame right after host release.
  task automatic rx_frame(input string tag, input logic [39:0] exp, input int chg_at,
                          input int abort_at, input bit hold_end, output int ones);
    int n;
    int lbad;
    int wbad;
    logic [39:0] d;
    lbad = 0; wbad = 0; ones = 0; d = 40'h0;
    measure(1'b1, n);
    check_eq({tag, "_resp_delay_in_range"}, 64'(n >= 60 && n <= 64), 64'd1);
    measure(1'b0, n);
    check_eq({tag, "_resp_low"}, 64'(n), 64'd160);
    measure(1'b1, n);
    check_eq({tag, "_resp_high"}, 64'(n), 64'd160);
    for (int i = 0; i < 40; i++) begin
      if (i == chg_at) {hi, hd, ti, td} = 32'h0;
      if (i == abort_at) begin
        r_rst_n = 1'b0;
        #1;
        check_eq({tag, "_abort_line"}, 64'(line), 64'd1);
        check_eq({tag, "_abort_busy"}, 64'(busy), 64'd0);
        return;
      end
      measure(1'b0, n);
      if (n != 100) lbad++;
      measure(1'b1, n);
      if (n == 140) begin
        ones++;
        d[39-i] = 1'b1;
      end else if (n != 52) begin
        wbad++;
      end
    end
    if (hold_end) begin
      // Host pulls low during END_LOW and keeps it low past frame end.
      r_host_low = 1'b1;
      repeat (440) @(negedge clk);
      r_host_low = 1'b0;
    end else begin
      measure(1'b0, n);
      check_eq({tag, "_end_low"}, 64'(n), 64'd100);
    end
    check_eq({tag, "_data"}, 64'(d), 64'(exp));
    check_eq({tag, "_bit_low_bad"}, 64'(lbad), 64'd0);
    check_eq({tag, "_bit_high_bad"}, 64'(wbad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int fd0, rej0, busy0, low0;
    r_rst_n = 1'b0;
    r_host_low = 1'b0;
    {hi, hd, ti, td} = 32'h0;
    repeat (4) @(negedge clk);
    check_eq("rst_line", 64'(line), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_frame_done", 64'(fd), 64'd0);
    check_eq("rst_start_rejected", 64'(rej), 64'd0);
    r_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame: checksum 0x37+0x00+0x18+0x05 = 0x54.
    {hi, hd, ti, td} = 32'h37001805;
    fd0 = fd_cnt;
    host_start(200);
    rx_frame("f1", 40'h3700180554, -1, -1, 1'b0, ones);
    repeat (5) @(negedge clk);
    check_eq("f1_frame_done_once", 64'(fd_cnt - fd0), 64'd1);
    check_eq("f1_busy_after", 64'(busy), 64'd0);

    // All 0xFF: checksum 0x3FC mod 256 = 0xFC -> 32 + 6 long highs.
    {hi, hd, ti, td} = 32'hFFFFFFFF;
    host_start(200);
    rx_frame("f2", 40'hFFFFFFFFFC, -1, -1, 1'b0, ones);
    check_eq("f2_long_highs", 64'(ones), 64'd38);
    repeat (5) @(negedge clk);

    // Short host pulse is rejected without touching the line.
    fd0 = fd_cnt; rej0 = rej_cnt; busy0 = busy_cnt; low0 = dut_low_cnt;
    host_start(100);
    repeat (300) @(negedge clk);
    check_eq("rej_pulse_once", 64'(rej_cnt - rej0), 64'd1);
    check_eq("rej_busy_cycles", 64'(busy_cnt - busy0), 64'd0);
    check_eq("rej_line_driven", 64'(dut_low_cnt - low0), 64'd0);
    check_eq("rej_no_frame", 64'(fd_cnt - fd0), 64'd0);

    // Inputs cleared at bit 5 do not affect the latched frame (checksum 0x114 -> 0x14).
    {hi, hd, ti, td} = 32'h12345678;
    host_start(200);
    rx_frame("f3", 40'h1234567814, 5, -1, 1'b0, ones);
    repeat (5) @(negedge clk);
    host_start(200);
    rx_frame("f4", 40'h0000000000, -1, -1, 1'b0, ones);
    repeat (5) @(negedge clk);

    // Reset at bit 20 aborts without frame_done; a new start then works.
    {hi, hd, ti, td} = 32'h01020304;
    fd0 = fd_cnt;
    host_start(200);
    rx_frame("f5", 40'h010203040A, -1, 20, 1'b0, ones);
    repeat (5) @(negedge clk);
    check_eq("f5_line_in_reset", 64'(line), 64'd1);
    r_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("f5_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    check_eq("f5_busy_after", 64'(busy), 64'd0);
    host_start(200);
    rx_frame("f6", 40'h010203040A, -1, -1, 1'b0, ones);
    repeat (5) @(negedge clk);
    check_eq("f6_frame_done_once", 64'(fd_cnt - fd0), 64'd1);

    // Back-to-back: low held from END_LOW is only 170 us after the frame -> rejected,
    // then a proper start gives the second frame.
    fd0 = fd_cnt; rej0 = rej_cnt;
    host_start(200);
    rx_frame("f7", 40'h010203040A, -1, -1, 1'b1, ones);
    repeat (20) @(negedge clk);
    check_eq("f7_frame_done_once", 64'(fd_cnt - fd0), 64'd1);
    check_eq("f7_held_low_rejected", 64'(rej_cnt - rej0), 64'd1);
    check_eq("f7_idle_after", 64'(busy), 64'd0);
    host_start(200);
    rx_frame("f8", 40'h010203040A, -1, -1, 1'b0, ones);
    repeat (5) @(negedge clk);
    check_eq("f8_two_frames", 64'(fd_cnt - fd0), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
